// File: rtl/heat_stencil_pipe_if.sv
// heat_stencil_pipe_if: node stream into and result stream out of heat_stencil_pipe.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both 1. A source holds valid and its payload stable until that edge. A sink
// may raise or drop ready at any time. Here in_ready depends only on
// out_valid/out_ready and never on in_valid.
//
// Signals (master = node producer / result consumer, slave = the pipe):
//   in_valid, in_center, in_up, in_down, in_left, in_right, in_tag, in_last -> slave
//   in_ready                                                                 <- slave
//   out_valid, out_center, out_last                                          <- slave
//   out_ready                                                                -> slave
// WIDTH must match the WIDTH of the attached heat_stencil_pipe.
interface heat_stencil_pipe_if #(
  parameter int WIDTH = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_center;
  logic signed [WIDTH-1:0] in_up;
  logic signed [WIDTH-1:0] in_down;
  logic signed [WIDTH-1:0] in_left;
  logic signed [WIDTH-1:0] in_right;
  logic [1:0]              in_tag;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_center;
  logic                    out_last;

  modport master (
    output in_valid, in_center, in_up, in_down, in_left, in_right, in_tag, in_last,
    input  in_ready,
    input  out_valid, out_center, out_last,
    output out_ready
  );

  modport slave (
    input  in_valid, in_center, in_up, in_down, in_left, in_right, in_tag, in_last,
    output in_ready,
    output out_valid, out_center, out_last,
    input  out_ready
  );
endinterface

// File: rtl/heat_stencil_pipe.sv
// heat_stencil_pipe: three-stage pipelined explicit heat-equation node update.
//   new = c + alpha * (up + down + left + right - 4c), signed WIDTH.FRAC fixed
//   point, saturating. A per-node tag selects free / hold / source / sink. A
//   running max of |new - c| is latched at the end of each sweep.
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   io            node input stream and result output stream (slave modport)
//   alpha         signed alpha*dt/dx^2, sampled with each accepted node
//   src_value     forced value for source nodes, sampled at accept
//   snk_value     forced value for sink nodes, sampled at accept
//   conv_thresh   unsigned convergence threshold on max_delta
//   sweep_done    one-cycle pulse after the last node of a sweep leaves
//   max_delta     largest |new - c| of the last completed sweep
//   converged     max_delta <= conv_thresh, updated with sweep_done
//
// Every stage moves together (global stall): advance = !out_valid || out_ready.
// A node accepted on edge k is presented on out_* after edge k+2 and is taken
// downstream on edge k+3 at the earliest.
module heat_stencil_pipe #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 27
) (
  input  logic                    clk,
  input  logic                    reset_n,
  heat_stencil_pipe_if.slave      io,
  input  logic signed [WIDTH-1:0] alpha,
  input  logic signed [WIDTH-1:0] src_value,
  input  logic signed [WIDTH-1:0] snk_value,
  input  logic [WIDTH-1:0]        conv_thresh,
  output logic                    sweep_done,
  output logic [WIDTH-1:0]        max_delta,
  output logic                    converged
);
  localparam int LW = WIDTH + 3;      // laplacian width, cannot overflow
  localparam int PW = 2 * WIDTH + 3;  // full product width

  localparam logic [1:0] TAG_FREE = 2'b00;
  localparam logic [1:0] TAG_HOLD = 2'b01;
  localparam logic [1:0] TAG_SRC  = 2'b10;
  localparam logic [1:0] TAG_SNK  = 2'b11;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic advance;
  assign advance     = !io.out_valid || io.out_ready;
  assign io.in_ready = advance;

  // ---------------- S1: laplacian ----------------
  logic signed [LW-1:0] up_x, dn_x, lf_x, rt_x, c_x, lap_c;
  assign up_x  = {{3{io.in_up[WIDTH-1]}},     io.in_up};
  assign dn_x  = {{3{io.in_down[WIDTH-1]}},   io.in_down};
  assign lf_x  = {{3{io.in_left[WIDTH-1]}},   io.in_left};
  assign rt_x  = {{3{io.in_right[WIDTH-1]}},  io.in_right};
  assign c_x   = {{3{io.in_center[WIDTH-1]}}, io.in_center};
  assign lap_c = up_x + dn_x + lf_x + rt_x - (c_x <<< 2);

  logic                    s1_valid, s1_last;
  logic [1:0]              s1_tag;
  logic signed [WIDTH-1:0] s1_c, s1_alpha, s1_force;
  logic signed [LW-1:0]    s1_lap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_tag   <= TAG_FREE;
      s1_c     <= '0;
      s1_alpha <= '0;
      s1_force <= '0;
      s1_lap   <= '0;
    end else if (advance) begin
      s1_valid <= io.in_valid;
      s1_last  <= io.in_last;
      s1_tag   <= io.in_tag;
      s1_c     <= io.in_center;
      s1_alpha <= alpha;
      // Only one forced value is ever needed per node, so pick it here.
      s1_force <= (io.in_tag == TAG_SRC) ? src_value : snk_value;
      s1_lap   <= lap_c;
    end
  end

  // ---------------- S2: scaled step ----------------
  logic signed [PW-1:0]    a_x, l_x, prod, step_full;
  logic signed [WIDTH-1:0] step_sat;
  assign a_x       = {{(PW-WIDTH){s1_alpha[WIDTH-1]}}, s1_alpha};
  assign l_x       = {{(PW-LW){s1_lap[LW-1]}}, s1_lap};
  assign prod      = a_x * l_x;
  assign step_full = prod >>> FRAC;  // floor toward -inf

  // In range only when every bit above the WIDTH sign bit is a sign copy.
  always_comb begin
    step_sat = step_full[WIDTH-1:0];
    if (step_full[PW-1:WIDTH-1] != {(PW-WIDTH+1){step_full[PW-1]}})
      step_sat = step_full[PW-1] ? SAT_MIN : SAT_MAX;
  end

  logic                    s2_valid, s2_last;
  logic [1:0]              s2_tag;
  logic signed [WIDTH-1:0] s2_c, s2_force, s2_step;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_tag   <= TAG_FREE;
      s2_c     <= '0;
      s2_force <= '0;
      s2_step  <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_tag   <= s1_tag;
      s2_c     <= s1_c;
      s2_force <= s1_force;
      s2_step  <= step_sat;
    end
  end

  // ---------------- S3: sum, tag select, delta ----------------
  logic signed [WIDTH:0] sum_x, diff_x;
  logic [WIDTH:0]        abs_x;
  logic [WIDTH-1:0]      sum_sat, out_sel, delta_c;

  assign sum_x = {s2_c[WIDTH-1], s2_c} + {s2_step[WIDTH-1], s2_step};

  always_comb begin
    sum_sat = sum_x[WIDTH-1:0];
    if (sum_x[WIDTH] != sum_x[WIDTH-1])
      sum_sat = sum_x[WIDTH] ? SAT_MIN : SAT_MAX;
    out_sel = sum_sat;
    case (s2_tag)
      TAG_FREE: out_sel = sum_sat;
      TAG_HOLD: out_sel = s2_c;
      TAG_SRC:  out_sel = s2_force;
      TAG_SNK:  out_sel = s2_force;
      default:  out_sel = sum_sat;
    endcase
  end

  // |out - c| needs WIDTH+1 bits; clip it back into the positive WIDTH range.
  assign diff_x  = {out_sel[WIDTH-1], out_sel} - {s2_c[WIDTH-1], s2_c};
  assign abs_x   = diff_x[WIDTH] ? -diff_x : diff_x;
  assign delta_c = (abs_x[WIDTH:WIDTH-1] != 2'b00) ? SAT_MAX : abs_x[WIDTH-1:0];

  logic [WIDTH-1:0] out_delta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io.out_valid  <= 1'b0;
      io.out_center <= '0;
      io.out_last   <= 1'b0;
      out_delta     <= '0;
    end else if (advance) begin
      io.out_valid  <= s2_valid;
      io.out_center <= out_sel;
      io.out_last   <= s2_last;
      out_delta     <= delta_c;
    end
  end

  // ---------------- sweep max-change tracker ----------------
  logic [WIDTH-1:0] acc, acc_next;
  assign acc_next = (out_delta > acc) ? out_delta : acc;

  // Runs on the output handshake only, so stalls and bubbles never count.
  // The last node latches its own delta and clears acc in the same edge, so
  // the first node of the next sweep starts from zero with nothing lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= '0;
      max_delta  <= '0;
      converged  <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      if (io.out_valid && io.out_ready) begin
        if (io.out_last) begin
          max_delta  <= acc_next;
          converged  <= (acc_next <= conv_thresh);
          sweep_done <= 1'b1;
          acc        <= '0;
        end else begin
          acc <= acc_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_heat_stencil_pipe.sv
// tb_heat_stencil_pipe: self-checking bench for heat_stencil_pipe.
// Expected results come from ref_node, which evaluates the update rule with
// wide integer arithmetic, and from hand-derived constants.
module tb_heat_stencil_pipe;
  localparam int W    = 32;
  localparam int FRAC = 27;
  localparam logic signed [127:0] SMAX = (128'sd1 <<< (W-1)) - 128'sd1;
  localparam logic signed [127:0] SMIN = -(128'sd1 <<< (W-1));

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] alpha, src_value, snk_value, conv_thresh, max_delta;
  logic         sweep_done, converged;

  heat_stencil_pipe_if #(.WIDTH(W)) bus ();

  heat_stencil_pipe #(.WIDTH(W), .FRAC(FRAC)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .io          (bus),
    .alpha       (alpha),
    .src_value   (src_value),
    .snk_value   (snk_value),
    .conv_thresh (conv_thresh),
    .sweep_done  (sweep_done),
    .max_delta   (max_delta),
    .converged   (converged)
  );

  int errors = 0;
  int checks = 0;
  int dbl_pulse = 0;
  logic prev_sd = 1'b0;

  // {last, center} per node and {converged, max_delta} per sweep
  logic [W:0]   exp_q[$];
  logic [W:0]   obs_q[$];
  logic [W:0]   sw_exp_q[$];
  logic [W:0]   sw_obs_q[$];
  logic [W-1:0] model_acc = '0;

  // ---------------- reference model ----------------
  function automatic logic signed [127:0] sx(input logic [W-1:0] v);
    sx = {{(128-W){v[W-1]}}, v};
  endfunction

  function automatic void ref_node(input logic [W-1:0] c, u, d, l, r, a, src, snk,
                                   input logic [1:0] tag,
                                   output logic [W-1:0] o, output logic [W-1:0] dl);
    logic signed [127:0] lap, step, sum, diff;
    lap  = sx(u) + sx(d) + sx(l) + sx(r) - 4 * sx(c);
    step = (sx(a) * lap) >>> FRAC;
    if (step > SMAX) step = SMAX;
    else if (step < SMIN) step = SMIN;
    sum = sx(c) + step;
    if (sum > SMAX) sum = SMAX;
    else if (sum < SMIN) sum = SMIN;
    case (tag)
      2'b00:   o = sum[W-1:0];
      2'b01:   o = c;
      2'b10:   o = src;
      default: o = snk;
    endcase
    diff = sx(o) - sx(c);
    if (diff < 0) diff = -diff;
    if (diff > SMAX) diff = SMAX;
    dl = diff[W-1:0];
  endfunction

  // ---------------- monitors (record only) ----------------
  always @(negedge clk) begin : mon
    logic [W-1:0] o, dl;
    if (reset_n) begin
      if (bus.in_valid && bus.in_ready) begin
        ref_node(bus.in_center, bus.in_up, bus.in_down, bus.in_left, bus.in_right,
                 alpha, src_value, snk_value, bus.in_tag, o, dl);
        exp_q.push_back({bus.in_last, o});
        if (dl > model_acc) model_acc = dl;
        if (bus.in_last) begin
          sw_exp_q.push_back({(model_acc <= conv_thresh), model_acc});
          model_acc = '0;
        end
      end
      if (bus.out_valid && bus.out_ready) obs_q.push_back({bus.out_last, bus.out_center});
      if (sweep_done) begin
        sw_obs_q.push_back({converged, max_delta});
        if (prev_sd) dbl_pulse++;
      end
      prev_sd = sweep_done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] c, u, d, l, r, input logic [1:0] tag, input logic last);
    logic ok;
    int n;
    bus.in_valid  = 1'b1;
    bus.in_center = c;
    bus.in_up     = u;
    bus.in_down   = d;
    bus.in_left   = l;
    bus.in_right  = r;
    bus.in_tag    = tag;
    bus.in_last   = last;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_accept: in_ready stayed %0b for %0d cycles, required 1", ok, n);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic rand_node(input logic last);
    logic [1:0] tag;
    alpha = ($urandom_range(0, 3) == 0) ? $urandom() : $urandom_range(0, 32'h0800_0000);
    if ($urandom_range(0, 1) == 1) alpha = -alpha;
    src_value = $urandom();
    snk_value = $urandom();
    tag = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(1, 3));
    send($urandom(), $urandom(), $urandom(), $urandom(), $urandom(), tag, last);
  endtask

  task automatic wait_obs(input int n, output logic ok);
    int k;
    k = 0;
    while (obs_q.size() < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    ok = (obs_q.size() >= n);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: out_valid=%b out_last=%b, required 0 0", bus.out_valid, bus.out_last);
    end
    checks++;
    if (bus.out_center !== '0) begin
      errors++;
      $display("FAIL reset_center: got %h, required 0", bus.out_center);
    end
    checks++;
    if (sweep_done !== 1'b0 || max_delta !== '0 || converged !== 1'b0) begin
      errors++;
      $display("FAIL reset_sweep: sweep_done=%b max_delta=%h converged=%b, required 0 0 0",
               sweep_done, max_delta, converged);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int n;
    logic ok;
    logic [W:0] got, want;
    alpha = 32'h0100_0000;
    conv_thresh = 32'h0400_0000;
    send(32'h0, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 2'b00, 1'b1);
    idle();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 10);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL basic_latency: out_valid after %0d cycles, required 3", n);
    end
    checks++;
    if (bus.out_center !== 32'h0400_0000 || bus.out_last !== 1'b1) begin
      errors++;
      $display("FAIL basic_value: got center=%h last=%b, required 04000000 1", bus.out_center, bus.out_last);
    end
    wait_obs(1, ok);
    got  = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++;
    if (!ok || got !== want) begin
      errors++;
      $display("FAIL basic_model: got %h, required %h", got, want);
    end
    got = (sw_obs_q.size() > 0) ? sw_obs_q.pop_front() : 'x;
    checks++;
    if (got !== {1'b1, 32'h0400_0000}) begin
      errors++;
      $display("FAIL basic_sweep: got conv/max %h, required 1/04000000", got);
    end
    sw_exp_q.delete();
  endtask

  task automatic test_saturation();
    logic ok;
    logic [W:0] got;
    logic [W-1:0] want[2];
    want[0] = 32'h7FFF_FFFF;
    want[1] = 32'h8000_0000;
    alpha = 32'h0400_0000;
    send(32'h7800_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 2'b00, 1'b0);
    send(32'h8800_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 2'b00, 1'b1);
    idle();
    wait_obs(2, ok);
    for (int i = 0; i < 2; i++) begin
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++;
      if (got[W-1:0] !== want[i]) begin
        errors++;
        $display("FAIL sat[%0d]: got %h, required %h", i, got[W-1:0], want[i]);
      end
    end
    got = (sw_obs_q.size() > 0) ? sw_obs_q.pop_front() : 'x;
    checks++;
    if (got !== {1'b0, 32'h0800_0000}) begin
      errors++;
      $display("FAIL sat_sweep: got conv/max %h, required 0/08000000", got);
    end
    exp_q.delete();
    sw_exp_q.delete();
  endtask

  task automatic test_tags();
    logic ok;
    logic [W:0] got;
    logic [W-1:0] want_o[3];
    logic [W:0]   want_s[3];
    want_o[0] = 32'h1234_5678;
    want_o[1] = 32'h4000_0000;
    want_o[2] = 32'hC000_0000;
    want_s[0] = {1'b1, 32'h0};
    want_s[1] = {1'b1, 32'h2DCB_A988};
    want_s[2] = {1'b0, 32'h5234_5678};
    alpha = 32'h0100_0000;
    src_value = 32'h4000_0000;
    snk_value = 32'hC000_0000;
    conv_thresh = 32'h3000_0000;
    for (int t = 1; t < 4; t++)
      send(32'h1234_5678, $urandom(), $urandom(), $urandom(), $urandom(), 2'(t), 1'b1);
    idle();
    wait_obs(3, ok);
    for (int i = 0; i < 3; i++) begin
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++;
      if (got[W-1:0] !== want_o[i]) begin
        errors++;
        $display("FAIL tag_out[%0d]: got %h, required %h", i + 1, got[W-1:0], want_o[i]);
      end
      got = (sw_obs_q.size() > 0) ? sw_obs_q.pop_front() : 'x;
      checks++;
      if (got !== want_s[i]) begin
        errors++;
        $display("FAIL tag_delta[%0d]: got conv/max %h, required %h", i + 1, got, want_s[i]);
      end
    end
    exp_q.delete();
    sw_exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic ok;
    logic [W:0] got, want;
    int cnt;
    conv_thresh = $urandom();
    fork
      begin
        for (int i = 0; i < 8; i++) rand_node(i == 7);
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          checks++;
          if (bus.in_ready !== !bus.out_valid) begin
            errors++;
            $display("FAIL bp_in_ready: got %b with out_valid=%b out_ready=0, required %b",
                     bus.in_ready, bus.out_valid, !bus.out_valid);
          end
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    wait_obs(8, ok);
    checks++;
    if (!ok || obs_q.size() != 8) begin
      errors++;
      $display("FAIL bp_count: got %0d outputs, required 8", obs_q.size());
    end
    cnt = 0;
    while (obs_q.size() > 0) begin
      got  = obs_q.pop_front();
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL bp_out[%0d]: got %h, required %h", cnt, got, want);
      end
      cnt++;
    end
    while (sw_obs_q.size() > 0) begin
      got  = sw_obs_q.pop_front();
      want = (sw_exp_q.size() > 0) ? sw_exp_q.pop_front() : 'x;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL bp_sweep: got conv/max %h, required %h", got, want);
      end
    end
    checks++;
    if (exp_q.size() != 0 || sw_exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_missing: %0d nodes and %0d sweeps never seen, required 0 0",
               exp_q.size(), sw_exp_q.size());
      exp_q.delete();
      sw_exp_q.delete();
    end
  endtask

  task automatic test_random();
    logic ok;
    logic done;
    logic [W:0] got, want;
    int cnt;
    done = 1'b0;
    conv_thresh = $urandom_range(0, 32'h1000_0000);
    fork
      begin
        for (int i = 0; i < 60; i++) rand_node((i == 59) || ($urandom_range(0, 5) == 0));
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_obs(60, ok);
    checks++;
    if (!ok || obs_q.size() != 60) begin
      errors++;
      $display("FAIL rnd_count: got %0d outputs, required 60", obs_q.size());
    end
    cnt = 0;
    while (obs_q.size() > 0) begin
      got  = obs_q.pop_front();
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL rnd_out[%0d]: got %h, required %h", cnt, got, want);
      end
      cnt++;
    end
    cnt = 0;
    while (sw_obs_q.size() > 0) begin
      got  = sw_obs_q.pop_front();
      want = (sw_exp_q.size() > 0) ? sw_exp_q.pop_front() : 'x;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL rnd_sweep[%0d]: got conv/max %h, required %h", cnt, got, want);
      end
      cnt++;
    end
    checks++;
    if (exp_q.size() != 0 || sw_exp_q.size() != 0) begin
      errors++;
      $display("FAIL rnd_missing: %0d nodes and %0d sweeps never seen, required 0 0",
               exp_q.size(), sw_exp_q.size());
      exp_q.delete();
      sw_exp_q.delete();
    end
  endtask

  task automatic test_convergence();
    logic ok;
    logic [W:0] got;
    logic [W-1:0] d[7];
    logic [W:0]   want[2];
    d[0] = 32'h10;  d[1] = 32'h300; d[2] = 32'h20; d[3] = 32'h5;
    d[4] = 32'h80;  d[5] = 32'h100; d[6] = 32'h40;
    want[0] = {1'b0, 32'h300};
    want[1] = {1'b1, 32'h100};
    conv_thresh = 32'h200;
    alpha = 32'h0100_0000;
    dbl_pulse = 0;
    for (int i = 0; i < 7; i++) begin
      src_value = d[i];
      send(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b10, (i == 3) || (i == 6));
    end
    idle();
    wait_obs(7, ok);
    for (int i = 0; i < 2; i++) begin
      got = (sw_obs_q.size() > 0) ? sw_obs_q.pop_front() : 'x;
      checks++;
      if (got !== want[i]) begin
        errors++;
        $display("FAIL conv_sweep[%0d]: got conv/max %h, required %h", i, got, want[i]);
      end
    end
    checks++;
    if (dbl_pulse != 0 || sw_obs_q.size() != 0) begin
      errors++;
      $display("FAIL conv_pulse: %0d wide pulses and %0d extra sweeps, required 0 0",
               dbl_pulse, sw_obs_q.size());
    end
    obs_q.delete();
    exp_q.delete();
    sw_obs_q.delete();
    sw_exp_q.delete();
  endtask

  task automatic test_mid_reset();
    logic ok;
    logic [W:0] got;
    conv_thresh = 32'h7FFF_FFFF;
    src_value = 32'h1000;
    send(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b10, 1'b0);
    idle();
    wait_obs(1, ok);
    got = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
    checks++;
    if (!ok || got !== {1'b0, 32'h1000}) begin
      errors++;
      $display("FAIL mr_partial: got %h, required 0/00001000", got);
    end
    for (int i = 0; i < 3; i++) rand_node(i == 2);
    reset_n = 1'b0;
    idle();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || sweep_done !== 1'b0 || max_delta !== '0 || converged !== 1'b0) begin
      errors++;
      $display("FAIL mr_clear: out_valid=%b sweep_done=%b max_delta=%h converged=%b, required 0 0 0 0",
               bus.out_valid, sweep_done, max_delta, converged);
    end
    exp_q.delete();
    obs_q.delete();
    sw_exp_q.delete();
    sw_obs_q.delete();
    model_acc = '0;
    prev_sd = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || sweep_done !== 1'b0) begin
        errors++;
        $display("FAIL mr_stale: out_valid=%b sweep_done=%b, required 0 0", bus.out_valid, sweep_done);
      end
    end
    @(posedge clk);
    #1;
    src_value = 32'h20;
    send(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b10, 1'b1);
    idle();
    wait_obs(1, ok);
    got = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
    checks++;
    if (!ok || got !== {1'b1, 32'h20}) begin
      errors++;
      $display("FAIL mr_after: got %h, required 1/00000020", got);
    end
    got = (sw_obs_q.size() > 0) ? sw_obs_q.pop_front() : 'x;
    checks++;
    if (got !== {1'b1, 32'h20}) begin
      errors++;
      $display("FAIL mr_sweep: got conv/max %h, required 1/00000020", got);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_center = '0;
    bus.in_up     = '0;
    bus.in_down   = '0;
    bus.in_left   = '0;
    bus.in_right  = '0;
    bus.in_tag    = 2'b00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    alpha         = '0;
    src_value     = '0;
    snk_value     = '0;
    conv_thresh   = '0;
    test_reset();
    test_basic();
    test_saturation();
    test_tags();
    test_backpressure();
    test_random();
    test_convergence();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required all tests to finish");
    $fatal(1, "watchdog");
  end
endmodule
